pu_work_allocator: RTL and testbench

//  Parametrised successor to the fixed-table preallocator. Maps a node's degree class to a PU count
//  via a runtime-programmable table and allocates that many PUs from a free pool (all-or-nothing).

---
 rtl/pu_work_allocator_pkg.sv | 40 ++++
 rtl/pu_work_allocator_pick.sv | 24 ++
 rtl/pu_work_allocator.sv | 130 +++++++++++++
 tb/tb_pu_work_allocator.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_work_allocator_pkg.sv
// PU work allocator shared types.
// FSM states, degree classes and default class-to-PU table.
`ifndef NUM_PU
`define NUM_PU 16
`endif

package pu_work_allocator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_GRANT
  } alloc_state_t;

  typedef enum logic [1:0] {
    CLS_LOW  = 2'd0,
    CLS_MID  = 2'd1,
    CLS_HIGH = 2'd2,
    CLS_HUB  = 2'd3
  } deg_class_t;

  localparam int DEF_LOW  = 1;
  localparam int DEF_MID  = 4;
  localparam int DEF_HIGH = 12;

  // Hub class takes the whole pool; classes past the hub get one PU.
  function automatic int default_count(
    input int cls,
    input int num_pu
  );
    case (cls)
      int'(CLS_LOW):  return DEF_LOW;
      int'(CLS_MID):  return DEF_MID;
      int'(CLS_HIGH): return DEF_HIGH;
      int'(CLS_HUB):  return num_pu;
      default:        return 1;
    endcase
  endfunction

endpackage

// File: rtl/pu_work_allocator_pick.sv
// Lowest-index PU picker.
// Selects the `need` lowest set bits of a free mask.
module pu_pick_lowest #(
  parameter int N  = 16,
  parameter int CW = 5
) (
  input  logic [N-1:0]  free_mask,
  input  logic [CW-1:0] need,
  output logic [N-1:0]  pick_mask
);

  always_comb begin
    logic [CW-1:0] taken;
    pick_mask = '0;
    taken     = '0;
    for (int i = 0; i < N; i++) begin
      if (free_mask[i] && (taken < need)) begin
        pick_mask[i] = 1'b1;
        taken        = taken + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pu_work_allocator.sv
// PU work allocator: class -> PU count via programmable table,
// all-or-nothing grant from a free pool, release port back.
module pu_work_allocator
  import pu_work_allocator_pkg::*;
#(
  parameter int NUM_PU    = `NUM_PU,
  parameter int NUM_CLASS = 4,
  parameter int CLS_W     = $clog2(NUM_CLASS),
  parameter int ID_W      = 32,
  parameter int CNT_W     = $clog2(NUM_PU + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CLS_W-1:0]  req_class,
  input  logic [ID_W-1:0]   req_node_id,
  output logic              grant_valid,
  input  logic              grant_ready,
  output logic [NUM_PU-1:0] grant_mask,
  output logic [CNT_W-1:0]  grant_count,
  output logic [ID_W-1:0]   grant_node_id,
  input  logic              rel_valid,
  input  logic [NUM_PU-1:0] rel_mask,
  input  logic              cfg_we,
  input  logic [CLS_W-1:0]  cfg_class,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic [CNT_W-1:0]  free_count,
  output logic [15:0]       stall_cycles,
  output logic              err_dbl_release
);

  alloc_state_t      state_q, state_d;
  logic [CNT_W-1:0]  tbl_q [NUM_CLASS];
  logic [NUM_PU-1:0] free_q, free_d;
  logic [NUM_PU-1:0] pick, alloc, rel;
  logic [CNT_W-1:0]  need_q, raw, need_d;
  logic [CNT_W-1:0]  pop_d;
  logic [ID_W-1:0]   id_q;
  logic              accept, do_alloc, stall_inc;

  pu_pick_lowest #(
    .N  (NUM_PU),
    .CW (CNT_W)
  ) u_pick (
    .free_mask (free_q),
    .need      (need_q),
    .pick_mask (pick)
  );

  // Table keeps the raw value; clamp to [1, NUM_PU] on lookup.
  assign raw    = tbl_q[req_class];
  assign need_d = (raw == '0) ? CNT_W'(1) :
                  (raw > CNT_W'(NUM_PU)) ? CNT_W'(NUM_PU) : raw;

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    do_alloc  = 1'b0;
    stall_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        accept = req_valid;
        if (req_valid) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (free_count >= need_q) begin
          do_alloc = 1'b1;
          state_d  = ST_GRANT;
        end else begin
          stall_inc = 1'b1;
        end
      end
      ST_GRANT: begin
        if (grant_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign alloc  = do_alloc ? pick : '0;
  assign rel    = rel_valid ? rel_mask : '0;
  assign free_d = (free_q & ~alloc) | rel;

  always_comb begin
    pop_d = '0;
    for (int i = 0; i < NUM_PU; i++)
      pop_d = pop_d + CNT_W'(free_d[i]);
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign grant_valid = (state_q == ST_GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      free_q          <= '1;
      free_count      <= CNT_W'(NUM_PU);
      need_q          <= '0;
      id_q            <= '0;
      grant_mask      <= '0;
      grant_count     <= '0;
      grant_node_id   <= '0;
      stall_cycles    <= '0;
      err_dbl_release <= 1'b0;
      for (int c = 0; c < NUM_CLASS; c++)
        tbl_q[c] <= CNT_W'(default_count(c, NUM_PU));
    end else begin
      state_q    <= state_d;
      free_q     <= free_d;
      free_count <= pop_d;
      if (accept) begin
        need_q <= need_d;
        id_q   <= req_node_id;
      end
      if (do_alloc) begin
        grant_mask    <= pick;
        grant_count   <= need_q;
        grant_node_id <= id_q;
      end
      if (stall_inc && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
      if (|(rel & free_q))
        err_dbl_release <= 1'b1;
      if (cfg_we)
        tbl_q[cfg_class] <= cfg_count;
    end
  end

endmodule

// File: tb/tb_pu_work_allocator.sv
// Bench for pu_work_allocator: pool/table model checked every
// cycle, plus directed vectors with literal expectations.
module tb_pu_work_allocator;

  localparam int NPU  = 16;
  localparam int NCLS = 4;
  localparam int CLSW = 2;
  localparam int IDW  = 32;
  localparam int CW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [CLSW-1:0] req_class = '0;
  logic [IDW-1:0]  req_node_id = '0;
  logic            grant_valid;
  logic            grant_ready = 1'b0;
  logic [NPU-1:0]  grant_mask;
  logic [CW-1:0]   grant_count;
  logic [IDW-1:0]  grant_node_id;
  logic            rel_valid = 1'b0;
  logic [NPU-1:0]  rel_mask = '0;
  logic            cfg_we = 1'b0;
  logic [CLSW-1:0] cfg_class = '0;
  logic [CW-1:0]   cfg_count = '0;
  logic [CW-1:0]   free_count;
  logic [15:0]     stall_cycles;
  logic            err_dbl_release;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pu_work_allocator #(
    .NUM_PU    (NPU),
    .NUM_CLASS (NCLS),
    .CLS_W     (CLSW),
    .ID_W      (IDW),
    .CNT_W     (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_class       (req_class),
    .req_node_id     (req_node_id),
    .grant_valid     (grant_valid),
    .grant_ready     (grant_ready),
    .grant_mask      (grant_mask),
    .grant_count     (grant_count),
    .grant_node_id   (grant_node_id),
    .rel_valid       (rel_valid),
    .rel_mask        (rel_mask),
    .cfg_we          (cfg_we),
    .cfg_class       (cfg_class),
    .cfg_count       (cfg_count),
    .free_count      (free_count),
    .stall_cycles    (stall_cycles),
    .err_dbl_release (err_dbl_release)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int ones(input logic [NPU-1:0] v);
    int n = 0;
    for (int i = 0; i < NPU; i++) n += int'(v[i]);
    return n;
  endfunction

  // Model: pool of free PUs, class table, one pending request, one held grant.
  logic [NPU-1:0] m_pool;
  int             m_tbl [NCLS];
  bit             m_pend, m_gnt, m_err;
  int             m_need, m_gcnt, m_stall;
  logic [IDW-1:0] m_id, m_gid;
  logic [NPU-1:0] m_gmask;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pool  = '1;
      m_tbl   = '{1, 4, 12, NPU};
      m_pend  = 0;
      m_gnt   = 0;
      m_err   = 0;
      m_need  = 0;
      m_gcnt  = 0;
      m_stall = 0;
      m_id    = '0;
      m_gid   = '0;
      m_gmask = '0;
    end else begin
      logic [NPU-1:0] take;
      int got, v;
      take = '0;
      if (m_gnt) begin
        if (grant_ready) m_gnt = 0;
      end else if (m_pend) begin
        if (ones(m_pool) >= m_need) begin
          got = 0;
          for (int i = 0; i < NPU; i++)
            if (m_pool[i] && got < m_need) begin
              take[i] = 1'b1;
              got++;
            end
          m_gmask = take;
          m_gcnt  = m_need;
          m_gid   = m_id;
          m_gnt   = 1;
          m_pend  = 0;
        end else if (m_stall < 65535) begin
          m_stall++;
        end
      end else if (req_valid) begin
        v      = m_tbl[req_class];
        m_need = (v < 1) ? 1 : (v > NPU) ? NPU : v;
        m_id   = req_node_id;
        m_pend = 1;
      end
      if (rel_valid && ((rel_mask & m_pool) != '0)) m_err = 1;
      m_pool = (m_pool & ~take) | (rel_valid ? rel_mask : '0);
      if (cfg_we) m_tbl[cfg_class] = int'(cfg_count);
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("req_ready", req_ready, !m_pend && !m_gnt);
      chk("grant_valid", grant_valid, m_gnt);
      chk("free_count", free_count, ones(m_pool));
      chk("stall_cycles", stall_cycles, m_stall);
      chk("err_dbl_release", err_dbl_release, m_err);
      if (m_gnt) begin
        chk("grant_mask", grant_mask, m_gmask);
        chk("grant_count", grant_count, m_gcnt);
        chk("grant_node_id", grant_node_id, m_gid);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic req(input int cls, input int id);
    req_valid   = 1'b1;
    req_class   = CLSW'(cls);
    req_node_id = IDW'(id);
  endtask

  task automatic release_pu(input logic [NPU-1:0] m);
    rel_valid = 1'b1;
    rel_mask  = m;
    tick();
    rel_valid = 1'b0;
    rel_mask  = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_free_count", free_count, 16);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_err", err_dbl_release, 0);

    // class 2 on a full pool
    req(2, 'hA);
    tick();
    req_valid = 1'b0;
    chk("c2_accept_ready", req_ready, 0);
    chk("c2_accept_free", free_count, 16);
    tick();
    chk("c2_valid", grant_valid, 1);
    chk("c2_mask", grant_mask, 16'h0FFF);
    chk("c2_count", grant_count, 12);
    chk("c2_id", grant_node_id, 'hA);
    chk("c2_free", free_count, 4);
    grant_ready = 1'b1;
    tick();
    chk("c2_taken_valid", grant_valid, 0);
    chk("c2_taken_ready", req_ready, 1);

    // class 1 takes the remaining four
    req(1, 'hB);
    tick();
    req_valid = 1'b0;
    tick();
    chk("c1_mask", grant_mask, 16'hF000);
    chk("c1_free", free_count, 0);
    tick();

    // class 0 stalls on empty pool until a release
    req(0, 'hC);
    tick();
    req_valid = 1'b0;
    tick(3);
    chk("c0_stall3", stall_cycles, 3);
    grant_ready = 1'b0;
    release_pu(16'h0001);
    chk("c0_not_yet", grant_valid, 0);
    tick();
    chk("c0_valid", grant_valid, 1);
    chk("c0_mask", grant_mask, 16'h0001);
    chk("c0_id", grant_node_id, 'hC);
    chk("c0_stall4", stall_cycles, 4);
    tick(5);
    chk("hold_valid", grant_valid, 1);
    chk("hold_mask", grant_mask, 16'h0001);
    chk("hold_ready", req_ready, 0);
    grant_ready = 1'b1;
    tick();
    chk("hold_taken", grant_valid, 0);
    release_pu(16'hFFFF);
    chk("all_back", free_count, 16);

    // table programming: 0 clamps to 1, 20 clamps to NUM_PU
    cfg_we    = 1'b1;
    cfg_class = 2'd3;
    cfg_count = 5'd0;
    tick();
    cfg_count = 5'd20;
    req(3, 'hD);
    tick();
    cfg_we    = 1'b0;
    req_valid = 1'b0;
    tick();
    chk("c3_zero_count", grant_count, 1);
    chk("c3_zero_mask", grant_mask, 16'h0001);
    tick();
    release_pu(16'h0001);
    req(3, 'hE);
    tick();
    req_valid = 1'b0;
    tick();
    chk("c3_big_count", grant_count, 16);
    chk("c3_big_mask", grant_mask, 16'hFFFF);
    chk("c3_big_free", free_count, 0);
    tick();
    release_pu(16'hFFFF);

    // double release
    release_pu(16'h0001);
    chk("dbl_err", err_dbl_release, 1);
    chk("dbl_free", free_count, 16);
    tick();
    chk("dbl_sticky", err_dbl_release, 1);

    // release in the same cycle as an allocation
    req(2, 'hF);
    tick();
    req_valid = 1'b0;
    tick(2);
    req(1, 'h10);
    tick();
    req_valid = 1'b0;
    release_pu(16'h0003);
    chk("same_mask", grant_mask, 16'hF000);
    chk("same_free", free_count, 2);
    tick();
    release_pu(16'hFFFC);
    chk("same_all_back", free_count, 16);

    // reset while a grant is held
    cfg_we    = 1'b1;
    cfg_class = 2'd0;
    cfg_count = 5'd5;
    tick();
    cfg_we      = 1'b0;
    grant_ready = 1'b0;
    req(0, 'h11);
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre_rst_mask", grant_mask, 16'h001F);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", grant_valid, 0);
    chk("mid_rst_free", free_count, 16);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_err", err_dbl_release, 0);
    tick(2);
    rst_n       = 1'b1;
    grant_ready = 1'b1;
    req(0, 'h12);
    tick();
    req_valid = 1'b0;
    tick();
    chk("post_rst_count", grant_count, 1);
    chk("post_rst_mask", grant_mask, 16'h0001);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
